inst_fetch: RTL
===============

Name: inst_fetch

Overview:
Instruction fetch stage of the 8-bit CPU; it sits directly upstream of the instruction decoder.
- Holds the program counter and issues single-beat reads to program memory.
- Captures the returned byte into the instruction register (ir) and presents it to the decoder's cmd input with a valid/ready handshake.
- Accepts control-flow redirects (jump/branch) and a halt request from the execute stage.

Parameters:
AW, 8, program memory address width (PC width)
DW, 8, instruction width (ir / mem_rdata width)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
mem_req  out  1  read request to program memory
mem_addr  out  AW  read address; equals pc while mem_req=1
mem_ack  in  1  memory returns mem_rdata this cycle (may be high in the same cycle mem_req rises)
mem_rdata  in  DW  instruction byte, valid when mem_ack=1
ir  out  DW  instruction register; drives decoder cmd
ir_pc  out  AW  address ir was fetched from
ir_valid  out  1  ir holds a live instruction
ir_ready  in  1  downstream consumes ir this cycle when ir_valid=1
redirect  in  1  load a new PC and flush any fetched or in-flight instruction
redirect_pc  in  AW  target address for redirect
halt  in  1  level; stop fetching while high
halted  out  1  block is in the HALT state

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, drop=0.
- States:
  - IDLE: if halt, go to HALT; else go to REQ.
  - REQ: mem_req=1, mem_addr=pc.
    - On mem_ack with drop=0: ir<=mem_rdata, ir_pc<=pc, pc<=pc+1, go to FULL.
  - FULL: ir_valid=1, mem_req=0.
    - On ir_ready: if halt, go to HALT; else go to REQ.
  - HALT: halted=1, mem_req=0, ir_valid=0.
    - Leave to REQ the cycle after halt samples 0.
- Outputs are registered from state; no combinational path from inputs to mem_req or ir_valid.
- Throughput: with zero-wait memory (mem_ack in the first REQ cycle) and ir_ready held 1, one instruction every 2 cycles. First ir_valid appears 2 cycles after rst deasserts (IDLE→REQ→FULL).
- Memory handshake rule: once mem_req=1 it stays high with mem_addr stable until mem_ack. It is never withdrawn, including on redirect or halt.
- PC arithmetic: modulo 2^AW; pc=0xFF increments to 0x00 with no flag.
- Redirect (priority over every other event, including ir_ready in the same cycle):
  - In IDLE, FULL or HALT: pc<=redirect_pc, ir_valid<=0. Any held ir is discarded and not counted as consumed. Next state is REQ, or HALT if halt=1.
  - In REQ without mem_ack: pc<=redirect_pc, drop<=1, stay in REQ. mem_addr keeps the old address until ack. On that ack, data is discarded and drop<=0; the next REQ cycle uses the new pc.
  - In REQ with mem_ack in the same cycle: data is discarded, pc<=redirect_pc, stay in REQ.
  - Back-to-back redirects: the last one wins.
- Halt:
  - Sampled only in IDLE, on FULL consume, and in HALT.
  - Halt during REQ completes the outstanding fetch. The instruction is presented in FULL and must be consumed before HALT is entered.
- Reset mid-operation: rst overrides everything and any outstanding memory transaction is abandoned. The memory model must tolerate this; memory is reset by the same rst.

Decomposition:
- cpu_pkg holds:
  - AW/DW defaults;
  - RESET_PC;
  - fetch state enum (IDLE, REQ, FULL, HALT), 2-bit encoding.
- One sub-module, program_counter:
  - inputs: clk, rst, load, load_val, inc;
  - output: pc;
  - load has priority over inc;
  - increment wraps.
- The FSM, drop flag and ir register stay in inst_fetch.

Test Plan:
1. Reset release, zero-wait memory returning mem[a]=a+0x10, ir_ready=1 → ir sequence 0x10,0x11,0x12 with ir_pc 0,1,2; ir_valid high every other cycle.
2. Memory with 3 wait cycles and ir_ready held 0 for 4 cycles → mem_addr stable during wait; ir=0x10 held with ir_valid=1 until ready; no second mem_req while FULL.
3. pc=0xFF fetch → ir_pc=0xFF, next mem_addr=0x00.
4. Redirect to 0x40 while REQ is waiting on addr 0x05 → mem_addr stays 0x05 until ack; that data never appears on ir; next ir_pc=0x40. Repeat with redirect coincident with ack and with ir_ready in FULL → same result.
5. halt=1 while REQ is outstanding → fetched instruction is presented and consumed, then halted=1 and mem_req=0. Deassert halt → fetch resumes at the next pc. Redirect to 0x20 while halted → first fetch after release is from 0x20.
6. rst pulsed while in REQ and while in FULL → next cycle all outputs are at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset PC and fetch state encoding for the 8-bit CPU
//
// Purpose : common definitions imported by the fetch stage and its program counter.
// Contents: CPU_AW / CPU_DW default widths, CPU_RESET_PC, fetch_state_e (2-bit).
package cpu_pkg;

  localparam int unsigned CPU_AW       = 8;
  localparam int unsigned CPU_DW       = 8;
  localparam int unsigned CPU_RESET_PC = 0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_FULL = 2'd2,
    FETCH_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_program_counter.sv
// rtl/inst_fetch_program_counter.sv - program counter register with load and wrapping increment
//
// Purpose : holds the fetch PC; load has priority over increment, increment wraps modulo 2^AW.
// Ports   : i_clk, i_rst (sync, active-high), i_load, i_load_val[AW], i_inc -> o_pc[AW]
module program_counter
  import cpu_pkg::*;
#(
  parameter int unsigned AW       = CPU_AW,
  parameter int unsigned RESET_PC = CPU_RESET_PC
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_inc,
  output logic [AW-1:0] o_pc
);

  logic [AW-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= AW'(RESET_PC);
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + AW'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, single-beat memory reads, ir handshake
//
// Purpose : fetches one instruction byte at a time from program memory into ir and
//           presents it to the decoder with valid/ready; handles redirect and halt.
// Ports   : i_clk, i_rst (sync, active-high)
//           o_mem_req, o_mem_addr[AW], i_mem_ack, i_mem_rdata[DW]   program memory read
//           o_ir[DW], o_ir_pc[AW], o_ir_valid, i_ir_ready          decoder handshake
//           i_redirect, i_redirect_pc[AW]                          control-flow redirect
//           i_halt, o_halted                                       halt request / status
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned AW       = CPU_AW,
  parameter int unsigned DW       = CPU_DW,
  parameter int unsigned RESET_PC = CPU_RESET_PC
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [DW-1:0] o_ir,
  output logic [AW-1:0] o_ir_pc,
  output logic          o_ir_valid,
  input  logic          i_ir_ready,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  input  logic          i_halt,
  output logic          o_halted
);

  fetch_state_e  r_state;
  fetch_state_e  w_next;
  logic          r_drop;      // outstanding read belongs to a flushed stream
  logic [AW-1:0] r_req_addr;  // address of the outstanding read while r_drop=1
  logic [DW-1:0] r_ir;
  logic [AW-1:0] r_ir_pc;
  logic [AW-1:0] w_pc;
  logic          w_load;
  logic          w_inc;
  logic          w_accept;

  program_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (i_redirect_pc),
    .i_inc      (w_inc),
    .o_pc       (w_pc)
  );

  // Redirect outranks everything; halt is only looked at where the stage is idle
  // or has just handed off an instruction, so an outstanding read always completes.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        w_load = i_redirect;
        w_next = i_halt ? FETCH_HALT : FETCH_REQ;
      end
      FETCH_REQ: begin
        if (i_redirect) begin
          w_load = 1'b1;
        end else if (i_mem_ack && !r_drop) begin
          w_inc  = 1'b1;
          w_next = FETCH_FULL;
        end
      end
      FETCH_FULL: begin
        if (i_redirect) begin
          w_load = 1'b1;
          w_next = i_halt ? FETCH_HALT : FETCH_REQ;
        end else if (i_ir_ready) begin
          w_next = i_halt ? FETCH_HALT : FETCH_REQ;
        end
      end
      FETCH_HALT: begin
        w_load = i_redirect;
        w_next = i_halt ? FETCH_HALT : FETCH_REQ;
      end
      default: w_next = FETCH_IDLE;
    endcase
  end

  assign w_accept = (r_state == FETCH_REQ) && i_mem_ack && !r_drop && !i_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= FETCH_IDLE;
      r_drop     <= 1'b0;
      r_req_addr <= AW'(RESET_PC);
      r_ir       <= '0;
      r_ir_pc    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ir    <= i_mem_rdata;
        r_ir_pc <= w_pc;
      end
      // A redirect without ack leaves the read pending; remember its address so
      // mem_addr stays stable while the PC already points at the new target.
      if (r_state == FETCH_REQ) begin
        if (i_mem_ack) begin
          r_drop <= 1'b0;
        end else if (i_redirect) begin
          if (!r_drop) begin
            r_req_addr <= w_pc;
          end
          r_drop <= 1'b1;
        end
      end
    end
  end

  assign o_mem_req  = (r_state == FETCH_REQ);
  assign o_mem_addr = ((r_state == FETCH_REQ) && r_drop) ? r_req_addr : w_pc;
  assign o_ir       = r_ir;
  assign o_ir_pc    = r_ir_pc;
  assign o_ir_valid = (r_state == FETCH_FULL);
  assign o_halted   = (r_state == FETCH_HALT);

endmodule
